// File: rtl/muldiv_execution_unit_pkg.sv
// Shared RV32M execution-unit definitions: op encoding, FSM states, forwarding selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_defs;

  // Default datapath width used across the core.
  localparam int XLEN = 32;

  // M-extension operation, encoded directly as funct3.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [1:0] FWD_WB     = 2'b01;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic md_is_div(input md_op_t op);
    logic [2:0] bits;
    bits = op;
    return bits[2];
  endfunction

endpackage

// File: rtl/muldiv_execution_unit_if.sv
// Request/result bundle of the multiply/divide unit (EX stage side <-> unit).
// Requests: i_valid/o_ready, i_funct3, i_rs1/i_rs2 with forwarding selects and EX/MEM, WB values, i_flush.
// Results: o_busy stall request, o_valid one-cycle strobe, o_result held between strobes.
interface muldiv_execution_unit_if #(
  parameter int NB_WORD = riscv_defs::XLEN
);
  logic               i_valid;
  logic               o_ready;
  logic [2:0]         i_funct3;
  logic [NB_WORD-1:0] i_rs1;
  logic [NB_WORD-1:0] i_rs2;
  logic [1:0]         i_forward_rs1;
  logic [1:0]         i_forward_rs2;
  logic [NB_WORD-1:0] i_ex_mem_alu_res;
  logic [NB_WORD-1:0] i_wb_res;
  logic               i_flush;
  logic               o_busy;
  logic               o_valid;
  logic [NB_WORD-1:0] o_result;

  modport master (
    output i_valid, i_funct3, i_rs1, i_rs2, i_forward_rs1, i_forward_rs2,
           i_ex_mem_alu_res, i_wb_res, i_flush,
    input  o_ready, o_busy, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_funct3, i_rs1, i_rs2, i_forward_rs1, i_forward_rs2,
           i_ex_mem_alu_res, i_wb_res, i_flush,
    output o_ready, o_busy, o_valid, o_result
  );
endinterface

// File: rtl/muldiv_execution_unit_operand_forward_mux.sv
// Operand forwarding mux: EX/MEM (2'b10), WB (2'b01), else register-file value.
// Latency: combinational.
// Backpressure: none.
module operand_forward_mux
  import riscv_defs::*;
#(
  parameter int NB_WORD = XLEN
) (
  input  logic [1:0]         i_sel,
  input  logic [NB_WORD-1:0] i_reg,
  input  logic [NB_WORD-1:0] i_ex_mem,
  input  logic [NB_WORD-1:0] i_wb,
  output logic [NB_WORD-1:0] o_operand
);
  always_comb begin
    o_operand = i_reg;
    if (i_sel == FWD_EX_MEM)  o_operand = i_ex_mem;
    else if (i_sel == FWD_WB) o_operand = i_wb;
  end
endmodule

// File: rtl/muldiv_execution_unit.sv
// Iterative RV32M multiply/divide unit; one op at a time, shared counter and FSM.
// Latency: NB_WORD+1 cycles from accept to o_valid; divide-by-zero/overflow in 1 cycle.
// Backpressure: o_ready only in IDLE; o_busy stalls the pipeline until the result strobe.
module muldiv_execution_unit
  import riscv_defs::*;
#(
  parameter int NB_WORD = riscv_defs::XLEN
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  muldiv_execution_unit_if.slave  bus
);
  localparam int NB_CNT = $clog2(NB_WORD);

  logic [NB_WORD-1:0] rs1_fwd, rs2_fwd;

  operand_forward_mux #(.NB_WORD(NB_WORD)) u_fwd_rs1 (
    .i_sel(bus.i_forward_rs1), .i_reg(bus.i_rs1), .i_ex_mem(bus.i_ex_mem_alu_res),
    .i_wb(bus.i_wb_res), .o_operand(rs1_fwd)
  );

  operand_forward_mux #(.NB_WORD(NB_WORD)) u_fwd_rs2 (
    .i_sel(bus.i_forward_rs2), .i_reg(bus.i_rs2), .i_ex_mem(bus.i_ex_mem_alu_res),
    .i_wb(bus.i_wb_res), .o_operand(rs2_fwd)
  );

  md_state_t            state_q, state_d;
  md_op_t               op_q;
  logic                 neg_q;
  logic [NB_CNT-1:0]    cnt_q;
  // MUL: {partial product, multiplier}. DIV: low half is dividend, shifting into quotient.
  logic [2*NB_WORD-1:0] acc_q;
  logic [NB_WORD-1:0]   rem_q;
  logic [NB_WORD-1:0]   opb_q;   // multiplicand or divisor magnitude
  logic [NB_WORD-1:0]   result_q;
  logic                 valid_q;

  // Accept-time decode.
  md_op_t             op_in;
  logic               accept, sgn1, sgn2, neg_in, div_zero, div_ovf, special;
  logic [NB_WORD-1:0] mag1, mag2, special_res;

  assign op_in  = md_op_t'(bus.i_funct3);
  assign accept = bus.i_valid && (state_q == MD_IDLE) && !bus.i_flush;
  assign sgn1   = rs1_fwd[NB_WORD-1] && (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign sgn2   = rs2_fwd[NB_WORD-1] && (op_in inside {MD_MULH, MD_DIV, MD_REM});
  assign mag1   = sgn1 ? (~rs1_fwd + 1'b1) : rs1_fwd;
  assign mag2   = sgn2 ? (~rs2_fwd + 1'b1) : rs2_fwd;
  // Remainder follows the dividend; quotient and product follow the XOR of signs.
  assign neg_in = (op_in == MD_REM) ? sgn1 : (sgn1 ^ sgn2);

  assign div_zero = md_is_div(op_in) && (rs2_fwd == '0);
  assign div_ovf  = (op_in inside {MD_DIV, MD_REM}) &&
                    (rs1_fwd == {1'b1, {(NB_WORD-1){1'b0}}}) && (rs2_fwd == '1);
  assign special  = div_zero || div_ovf;

  // funct3[1] selects the remainder variant within the divide family.
  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = bus.i_funct3[1] ? rs1_fwd : '1;
    else if (div_ovf) special_res = bus.i_funct3[1] ? '0 : rs1_fwd;
  end

  // One shift-add multiply step; the carry out of the high half shifts back in.
  logic [NB_WORD:0]     mul_hi_sum;
  logic [2*NB_WORD-1:0] mul_next, mul_full;
  assign mul_hi_sum = {1'b0, acc_q[2*NB_WORD-1:NB_WORD]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next   = {mul_hi_sum, acc_q[NB_WORD-1:1]};
  assign mul_full   = neg_q ? -mul_next : mul_next;

  // One restoring-divide step.
  logic [NB_WORD:0]     div_shift, div_trial;
  logic                 q_bit;
  logic [NB_WORD-1:0]   rem_next, quo_next;
  logic [2*NB_WORD-1:0] div_acc_next;
  assign div_shift    = {rem_q, acc_q[NB_WORD-1]};
  assign div_trial    = div_shift - {1'b0, opb_q};
  assign q_bit        = ~div_trial[NB_WORD];
  assign rem_next     = q_bit ? div_trial[NB_WORD-1:0] : div_shift[NB_WORD-1:0];
  assign quo_next     = {acc_q[NB_WORD-2:0], q_bit};
  assign div_acc_next = {acc_q[2*NB_WORD-1:NB_WORD], quo_next};

  logic [NB_WORD-1:0] res_fin;
  always_comb begin
    res_fin = '0;
    case (op_q)
      MD_MUL:                      res_fin = mul_full[NB_WORD-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_fin = mul_full[2*NB_WORD-1:NB_WORD];
      MD_DIV, MD_DIVU:             res_fin = neg_q ? -quo_next : quo_next;
      default:                     res_fin = neg_q ? -rem_next : rem_next;
    endcase
  end

  // FSM.
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= MD_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = special ? MD_DONE : MD_BUSY;
      MD_BUSY: if (cnt_q == NB_CNT'(NB_WORD-1)) state_d = MD_DONE;
      default: state_d = MD_IDLE;
    endcase
    if (bus.i_flush) state_d = MD_IDLE;
  end

  // Datapath.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= (state_d == MD_DONE);
      if (accept) begin
        op_q  <= op_in;
        neg_q <= neg_in;
        cnt_q <= '0;
        rem_q <= '0;
        if (md_is_div(op_in)) begin
          acc_q <= {{NB_WORD{1'b0}}, mag1};
          opb_q <= mag2;
        end else begin
          acc_q <= {{NB_WORD{1'b0}}, mag2};
          opb_q <= mag1;
        end
        if (special && (state_d == MD_DONE)) result_q <= special_res;
      end else if (state_q == MD_BUSY && !bus.i_flush) begin
        cnt_q <= cnt_q + 1'b1;
        if (md_is_div(op_q)) begin
          acc_q <= div_acc_next;
          rem_q <= rem_next;
        end else begin
          acc_q <= mul_next;
        end
        if (state_d == MD_DONE) result_q <= res_fin;
      end
    end
  end

  assign bus.o_ready  = (state_q == MD_IDLE);
  assign bus.o_busy   = ((state_q == MD_IDLE) && bus.i_valid && !bus.i_flush) || (state_q == MD_BUSY);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
endmodule
